param_loader: RTL and testbench
===============================

# param_loader

Front-end input controller for the egg-drop board: debounces the three board buttons, captures the 16-bit switch value into the floor-count and resistance registers, and gates the CPU reset until both parameters are loaded and start is pressed. It produces the `init_floors` / `init_resistance` values and the CPU reset that the board top level feeds into the CPU core. It sits between the raw board I/O and the CPU, clocked by the undivided board clock.

## Interface

Parameters:
- `DATA_W`, 16: width of switch data and parameter registers.
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable samples required to accept a button level change; minimum 2.

Ports:
- `in_clk`  input  1  board clock; the only clock.
- `in_rst`  input  1  reset, synchronous, active-low.
- `in_data`  input  DATA_W  raw switch value, asynchronous.
- `btn_floors`  input  1  raw button, asynchronous: load floors.
- `btn_resistance`  input  1  raw button, asynchronous: load resistance.
- `btn_start`  input  1  raw button, asynchronous: start or re-arm.
- `init_floors`  output  DATA_W  latched floor count.
- `init_resistance`  output  DATA_W  latched resistance.
- `out_cpu_rst`  output  1  active-low CPU reset; 1 only in RUN.
- `out_state`  output  2  FSM state encoding (IDLE=0, PARTIAL=1, ARMED=2, RUN=3).
- `out_error`  output  1  sticky rejected-load flag.

## Operation

- **Synchronizer.** Each button and `in_data` pass through a 2-flop synchronizer.
- **Debouncer.** One per button.
  - Counter increments while the synchronized sample differs from the debounced level.
  - Counter clears on any equal sample.
  - On reaching `DEBOUNCE_CYCLES`, the debounced level flips and the counter clears.
  - A rising edge of the debounced level gives a registered one-cycle press pulse. Falling edges give nothing.
- **Loads.**
  - A floors press latches the synchronized `in_data` into `init_floors`.
  - A resistance press latches it into `init_resistance`.
- **Priority on same-cycle pulses.** floors > resistance > start. Lower-priority pulses in that cycle are dropped, not queued.
- **FSM.**
  - IDLE: neither parameter loaded since reset.
  - PARTIAL: exactly one parameter loaded.
  - ARMED: both loaded. A re-load of either keeps ARMED and overwrites the value.
  - Any state: each accepted load sets its per-parameter loaded bit; the next state follows from the loaded bits.
  - ARMED + start pulse -> RUN.
  - RUN: load pulses are ignored (registers frozen). A start pulse -> ARMED; `out_cpu_rst` drops for at least one cycle.
  - Start in IDLE or PARTIAL is ignored.
- **`out_error`.** Set by a rejected load (see Configuration). Cleared by the next accepted load of either parameter and by reset.
- **Reset.** Reset at any time, including mid-debounce or in RUN:
  - all registers return to reset values;
  - debounce counters and levels go to 0;
  - the FSM goes to IDLE.
  - A button held through reset release is seen as a new press after debounce.

## Timing

Reset values:
- `init_floors` = 0, `init_resistance` = 0
- `out_cpu_rst` = 0
- `out_state` = 0
- `out_error` = 0
- all debounce and synchronizer state = 0

Latency:
- Button first sampled high at edge k: the press pulse is high during cycle k+3+`DEBOUNCE_CYCLES`, and the register and state update at edge k+4+`DEBOUNCE_CYCLES`. Total L = `DEBOUNCE_CYCLES`+4 edges.
- `in_data` must be stable from edge k-2 through the pulse cycle.
- `out_cpu_rst` rises at the same edge the state enters RUN, and falls at the edge the state leaves RUN.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Bounce:
- A button glitch shorter than `DEBOUNCE_CYCLES` samples produces no pulse.
- A release shorter than `DEBOUNCE_CYCLES` during a hold does not retrigger.

## Configuration

`PARAM_LOADER_RANGE_CHECK_EN`:
- **Defined:**
  - A floors load with value 0 is rejected: register unchanged, loaded bit unchanged, `out_error` set.
  - A resistance load with value 0 or greater than the current `init_floors` is rejected the same way.
- **Undefined:**
  - Every load is accepted.
  - `out_error` is constant 0 and its logic is not built.

## Test plan

All tests use `DEBOUNCE_CYCLES`=4, so L=8.

- **Basic load and start.** Reset; `in_data`=100; hold floors for 10 cycles; then `in_data`=37 and hold resistance; then hold start.
  - `init_floors`=100 at edge k+8.
  - `out_state` goes 0 -> 1 -> 2 -> 3.
  - `out_cpu_rst`=1 in RUN; `init_resistance`=37.
- **Bounce rejection.** Toggle floors high 3 cycles, low 1 cycle, repeatedly.
  - No load; `out_state` stays 0.
  - Then a steady 4+ cycle hold loads after exactly L edges.
- **Simultaneous presses.** Floors and resistance pressed on the same edge with `in_data`=50.
  - Only `init_floors`=50; state 1; `init_resistance`=0.
- **Freeze and re-arm.** In RUN, press floors with `in_data`=7.
  - `init_floors` unchanged.
  - Then press start: state 2 and `out_cpu_rst`=0 at pulse+1.
  - Press start again: RUN.
- **Range check (macro defined).** Floors=0 -> `out_error`=1, state 0. Floors=10, then resistance=11 -> rejected, `out_error`=1. Resistance=10 -> accepted, `out_error`=0, state 2. With the macro undefined, floors=0 is accepted and `out_error` stays 0.
- **Mid-operation reset.** Assert `in_rst`=0 for 1 cycle in RUN while floors is held.
  - Next edge: all outputs at reset values.
  - With floors still held, reload occurs L edges after release.

Source files
------------

// File: rtl/param_loader.sv
// Button debounce, switch capture and CPU-reset gating for the egg-drop board.
// Optional build macro PARAM_LOADER_RANGE_CHECK_EN rejects zero / out-of-range loads.
module param_loader #(
    parameter int unsigned DATA_W          = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              btn_floors,
    input  logic              btn_resistance,
    input  logic              btn_start,
    output logic [DATA_W-1:0] init_floors,
    output logic [DATA_W-1:0] init_resistance,
    output logic              out_cpu_rst,
    output logic [1:0]        out_state,
    output logic              out_error
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned NBTN  = 3;
    localparam int unsigned B_FL  = 0;
    localparam int unsigned B_RS  = 1;
    localparam int unsigned B_ST  = 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PARTIAL = 2'd1,
        S_ARMED   = 2'd2,
        S_RUN     = 2'd3
    } state_e;

    logic [NBTN-1:0]             btn_s1_q, btn_s2_q;
    logic [DATA_W-1:0]           data_s1_q, data_s2_q;
    logic [NBTN-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [NBTN-1:0]             lvl_q, lvl_d;
    logic [NBTN-1:0]             lvl_prev_q;
    logic [NBTN-1:0]             pulse_q, pulse_d;

    logic [DATA_W-1:0]           floors_q, floors_d;
    logic [DATA_W-1:0]           res_q, res_d;
    logic                        ld_f_q, ld_f_d;
    logic                        ld_r_q, ld_r_d;
    state_e                      state_q, state_d;
    logic                        cpu_rst_q, cpu_rst_d;
    logic                        ok_f, ok_r;

`ifdef PARAM_LOADER_RANGE_CHECK_EN
    logic                        err_q, err_d;
    assign ok_f = (data_s2_q != '0);
    assign ok_r = (data_s2_q != '0) && (data_s2_q <= floors_q);
`else
    assign ok_f = 1'b1;
    assign ok_r = 1'b1;
`endif

    // Debounce: a level flips once the counter has seen DEBOUNCE_CYCLES differing samples.
    always_comb begin
        cnt_d = cnt_q;
        lvl_d = lvl_q;
        for (int i = 0; i < NBTN; i++) begin
            if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES)) begin
                cnt_d[i] = '0;
                lvl_d[i] = ~lvl_q[i];
            end else if (btn_s2_q[i] != lvl_q[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else begin
                cnt_d[i] = '0;
            end
        end
        pulse_d = lvl_q & ~lvl_prev_q;
    end

    // Load arbitration (floors > resistance > start) and state sequencing.
    always_comb begin
        floors_d = floors_q;
        res_d    = res_q;
        ld_f_d   = ld_f_q;
        ld_r_d   = ld_r_q;
        state_d  = state_q;
`ifdef PARAM_LOADER_RANGE_CHECK_EN
        err_d    = err_q;
`endif
        if (state_q == S_RUN) begin
            if (pulse_q[B_ST] && !pulse_q[B_FL] && !pulse_q[B_RS]) begin
                state_d = S_ARMED;
            end
        end else if (pulse_q[B_FL]) begin
            if (ok_f) begin
                floors_d = data_s2_q;
                ld_f_d   = 1'b1;
`ifdef PARAM_LOADER_RANGE_CHECK_EN
                err_d    = 1'b0;
            end else begin
                err_d    = 1'b1;
`endif
            end
        end else if (pulse_q[B_RS]) begin
            if (ok_r) begin
                res_d    = data_s2_q;
                ld_r_d   = 1'b1;
`ifdef PARAM_LOADER_RANGE_CHECK_EN
                err_d    = 1'b0;
            end else begin
                err_d    = 1'b1;
`endif
            end
        end else if (pulse_q[B_ST] && (state_q == S_ARMED)) begin
            state_d = S_RUN;
        end

        if ((state_q != S_RUN) && (pulse_q[B_FL] || pulse_q[B_RS])) begin
            unique case ({ld_f_d, ld_r_d})
                2'b00:   state_d = S_IDLE;
                2'b11:   state_d = S_ARMED;
                default: state_d = S_PARTIAL;
            endcase
        end
        cpu_rst_d = (state_d == S_RUN);
    end

    always_ff @(posedge in_clk) begin
        if (!in_rst) begin
            btn_s1_q   <= '0;
            btn_s2_q   <= '0;
            data_s1_q  <= '0;
            data_s2_q  <= '0;
            cnt_q      <= '0;
            lvl_q      <= '0;
            lvl_prev_q <= '0;
            pulse_q    <= '0;
            floors_q   <= '0;
            res_q      <= '0;
            ld_f_q     <= 1'b0;
            ld_r_q     <= 1'b0;
            state_q    <= S_IDLE;
            cpu_rst_q  <= 1'b0;
`ifdef PARAM_LOADER_RANGE_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            btn_s1_q   <= {btn_start, btn_resistance, btn_floors};
            btn_s2_q   <= btn_s1_q;
            data_s1_q  <= in_data;
            data_s2_q  <= data_s1_q;
            cnt_q      <= cnt_d;
            lvl_q      <= lvl_d;
            lvl_prev_q <= lvl_q;
            pulse_q    <= pulse_d;
            floors_q   <= floors_d;
            res_q      <= res_d;
            ld_f_q     <= ld_f_d;
            ld_r_q     <= ld_r_d;
            state_q    <= state_d;
            cpu_rst_q  <= cpu_rst_d;
`ifdef PARAM_LOADER_RANGE_CHECK_EN
            err_q      <= err_d;
`endif
        end
    end

    assign init_floors     = floors_q;
    assign init_resistance = res_q;
    assign out_cpu_rst     = cpu_rst_q;
    assign out_state       = state_q;
`ifdef PARAM_LOADER_RANGE_CHECK_EN
    assign out_error       = err_q;
`else
    assign out_error       = 1'b0;
`endif

endmodule

// File: tb/tb_param_loader.sv
// Directed bench for param_loader with DEBOUNCE_CYCLES=4 (load latency 8 edges).
module tb_param_loader;

    localparam int unsigned DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] data;
    logic              b_fl, b_rs, b_st;
    logic [DATA_W-1:0] floors, res;
    logic              cpu_rst, err;
    logic [1:0]        state;

    int n_cmp = 0;
    int n_err = 0;

    param_loader #(.DATA_W(DATA_W), .DEBOUNCE_CYCLES(4)) dut (
        .in_clk          (clk),
        .in_rst          (rst_n),
        .in_data         (data),
        .btn_floors      (b_fl),
        .btn_resistance  (b_rs),
        .btn_start       (b_st),
        .init_floors     (floors),
        .init_resistance (res),
        .out_cpu_rst     (cpu_rst),
        .out_state       (state),
        .out_error       (err)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; data = '0; b_fl = 1'b0; b_rs = 1'b0; b_st = 1'b0;
        step(3);
        check("rst_floors", 32'(floors), 32'd0);
        check("rst_res",    32'(res),    32'd0);
        check("rst_state",  32'(state),  32'd0);
        check("rst_cpu",    32'(cpu_rst), 32'd0);
        check("rst_err",    32'(err),    32'd0);
        rst_n = 1'b1;
        step(1);

        // Basic load and start
        data = 16'd100; b_fl = 1'b1;
        step(8);
        check("t1_fl_early", 32'(floors), 32'd0);
        check("t1_st_early", 32'(state),  32'd0);
        step(1);
        check("t1_fl",       32'(floors), 32'd100);
        check("t1_st_part",  32'(state),  32'd1);
        step(1);
        b_fl = 1'b0; data = 16'd37; b_rs = 1'b1;
        step(9);
        check("t1_res",      32'(res),    32'd37);
        check("t1_st_armed", 32'(state),  32'd2);
        check("t1_cpu_arm",  32'(cpu_rst), 32'd0);
        b_rs = 1'b0;
        step(10);
        b_st = 1'b1;
        step(8);
        check("t1_st_pre",   32'(state),  32'd2);
        step(1);
        check("t1_st_run",   32'(state),  32'd3);
        check("t1_cpu_run",  32'(cpu_rst), 32'd1);
        b_st = 1'b0;
        step(10);

        // Freeze in RUN, then re-arm and restart
        data = 16'd7; b_fl = 1'b1;
        step(9);
        check("fz_floors",   32'(floors), 32'd100);
        check("fz_state",    32'(state),  32'd3);
        b_fl = 1'b0;
        step(10);
        b_st = 1'b1;
        step(8);
        check("rearm_pre",   32'(cpu_rst), 32'd1);
        step(1);
        check("rearm_state", 32'(state),  32'd2);
        check("rearm_cpu",   32'(cpu_rst), 32'd0);
        b_st = 1'b0;
        step(10);
        b_st = 1'b1;
        step(9);
        check("rerun_state", 32'(state),  32'd3);
        check("rerun_cpu",   32'(cpu_rst), 32'd1);
        b_st = 1'b0;
        step(10);

        // Mid-operation reset with floors held
        data = 16'd55; b_fl = 1'b1;
        step(2);
        rst_n = 1'b0;
        step(1);
        check("mr_floors",   32'(floors), 32'd0);
        check("mr_res",      32'(res),    32'd0);
        check("mr_state",    32'(state),  32'd0);
        check("mr_cpu",      32'(cpu_rst), 32'd0);
        rst_n = 1'b1;
        step(8);
        check("mr_fl_early", 32'(floors), 32'd0);
        step(1);
        check("mr_fl",       32'(floors), 32'd55);
        check("mr_state1",   32'(state),  32'd1);
        b_fl = 1'b0;
        step(10);

        // Bounce rejection
        do_reset();
        check("bn_rst_state", 32'(state), 32'd0);
        data = 16'd20;
        for (int i = 0; i < 4; i++) begin
            b_fl = 1'b1;
            step(3);
            b_fl = 1'b0;
            step(1);
        end
        step(6);
        check("bn_floors",   32'(floors), 32'd0);
        check("bn_state",    32'(state),  32'd0);
        b_fl = 1'b1;
        step(8);
        check("bn_fl_early", 32'(floors), 32'd0);
        step(1);
        check("bn_fl",       32'(floors), 32'd20);
        check("bn_state1",   32'(state),  32'd1);
        b_fl = 1'b0;
        step(10);

        // Simultaneous floors + resistance, then start in PARTIAL
        do_reset();
        data = 16'd50; b_fl = 1'b1; b_rs = 1'b1;
        step(9);
        check("sim_floors",  32'(floors), 32'd50);
        check("sim_res",     32'(res),    32'd0);
        check("sim_state",   32'(state),  32'd1);
        b_fl = 1'b0; b_rs = 1'b0;
        step(10);
        b_st = 1'b1;
        step(10);
        check("part_start",  32'(state),  32'd1);
        check("part_cpu",    32'(cpu_rst), 32'd0);
        b_st = 1'b0;
        step(10);

        // Range checking
        do_reset();
        data = 16'd0; b_fl = 1'b1;
        step(9);
        b_fl = 1'b0;
`ifdef PARAM_LOADER_RANGE_CHECK_EN
        check("rc_f0_err",   32'(err),    32'd1);
        check("rc_f0_state", 32'(state),  32'd0);
        step(10);
        data = 16'd10; b_fl = 1'b1;
        step(9);
        b_fl = 1'b0;
        check("rc_f10",      32'(floors), 32'd10);
        check("rc_f10_err",  32'(err),    32'd0);
        step(10);
        data = 16'd11; b_rs = 1'b1;
        step(9);
        b_rs = 1'b0;
        check("rc_r11_err",  32'(err),    32'd1);
        check("rc_r11_res",  32'(res),    32'd0);
        check("rc_r11_st",   32'(state),  32'd1);
        step(10);
        data = 16'd10; b_rs = 1'b1;
        step(9);
        b_rs = 1'b0;
        check("rc_r10_res",  32'(res),    32'd10);
        check("rc_r10_err",  32'(err),    32'd0);
        check("rc_r10_st",   32'(state),  32'd2);
`else
        check("nc_f0_state", 32'(state),  32'd1);
        check("nc_f0_err",   32'(err),    32'd0);
        check("nc_f0_val",   32'(floors), 32'd0);
`endif
        step(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
